// File: rtl/deparser_pkg.sv
// Shared types and sizing helpers for the PHV deparser merge block.
package deparser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        PASS  = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH  = 256;
    localparam int DEF_TUSER_WIDTH = 128;
    localparam int DEF_HDR_SEGS    = 4;
    localparam int DEF_LEN_WIDTH   = 8;

    function automatic int bytes_per_beat(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int hdr_bytes(input int data_width, input int segs);
        return segs * (data_width / 8);
    endfunction

    // Width needed to hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/seg_byte_merge.sv
// Per-byte select between one header segment and a packet beat.
// Bytes below thr_i come from the header, the rest from the packet.
module seg_byte_merge #(
    parameter int DATA_WIDTH = 256,
    parameter int THR_WIDTH  = 6
) (
    input  logic [DATA_WIDTH-1:0] hdr_seg_i,
    input  logic [DATA_WIDTH-1:0] pkt_data_i,
    input  logic [THR_WIDTH-1:0]  thr_i,
    output logic [DATA_WIDTH-1:0] merged_o
);

    always_comb begin
        merged_o = pkt_data_i;
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (THR_WIDTH'(b) < thr_i) begin
                merged_o[b*8 +: 8] = hdr_seg_i[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/phv_deparser_merge.sv
// Writes a modified PHV header over the leading bytes of its packet; the rest passes through.
// Define DEPARSER_STATS_EN to add packet and truncation counters.
module phv_deparser_merge
    import deparser_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int C_S_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH,
    parameter int HDR_SEGS             = DEF_HDR_SEGS,
    parameter int LEN_WIDTH            = DEF_LEN_WIDTH
) (
    input  logic                                     CLK_156,
    input  logic                                     RESET_156,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]         s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]          s_axis_tuser,
    input  logic                                     s_axis_tvalid,
    output logic                                     s_axis_tready,
    input  logic                                     s_axis_tlast,
    input  logic [HDR_SEGS*C_S_AXIS_DATA_WIDTH-1:0]  s_hdr_data,
    input  logic [LEN_WIDTH-1:0]                     s_hdr_len,
    input  logic                                     s_hdr_valid,
    output logic                                     s_hdr_ready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]         m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]          m_axis_tuser,
    output logic                                     m_axis_tlast,
    output logic                                     m_axis_tvalid,
    input  logic                                     m_axis_tready,
    output state_t                                   dbg_state
`ifdef DEPARSER_STATS_EN
    ,
    output logic [31:0]                              stat_pkt_cnt,
    output logic [31:0]                              stat_trunc_cnt
`endif
);

    localparam int W         = C_S_AXIS_DATA_WIDTH;
    localparam int KW        = W / 8;
    localparam int UW        = C_S_AXIS_TUSER_WIDTH;
    localparam int BPB       = bytes_per_beat(W);
    localparam int HDR_BYTES = hdr_bytes(W, HDR_SEGS);
    localparam int BEAT_W    = cnt_width(HDR_SEGS);
    localparam int BYTE_W    = cnt_width(HDR_BYTES + BPB);
    localparam int THR_W     = cnt_width(BPB);

    // Handshake: a beat moves on a port in any cycle where valid and ready are both
    // high at the rising edge; valid never depends on ready, and the output register
    // may only be reloaded when it is empty or being drained (adv).

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;

    logic [W-1:0]        m_tdata_q;
    logic [KW-1:0]       m_tkeep_q;
    logic [UW-1:0]       m_tuser_q;
    logic                m_tlast_q;
    logic                m_tvalid_q;

    logic                adv, accept, end_pkt, hdr_done;
    logic [31:0]         len_eff, rem, thr32;
    logic [THR_W-1:0]    thr;
    logic [W-1:0]        hdr_seg, merged;

    assign adv           = !m_tvalid_q || m_axis_tready;
    assign s_axis_tready = (state_q != IDLE) && adv && !RESET_156;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign end_pkt       = accept && s_axis_tlast;
    assign s_hdr_ready   = end_pkt;
    assign dbg_state     = state_q;

    // Header bytes still owed to the current beat, clamped to one beat.
    always_comb begin
        len_eff  = (32'(s_hdr_len) > 32'(HDR_BYTES)) ? 32'(HDR_BYTES) : 32'(s_hdr_len);
        rem      = (len_eff > 32'(byte_cnt_q)) ? len_eff - 32'(byte_cnt_q) : 32'd0;
        thr32    = 32'd0;
        if (state_q == MERGE) begin
            thr32 = (rem > 32'(BPB)) ? 32'(BPB) : rem;
        end
        hdr_done = (32'(byte_cnt_q) + 32'(BPB)) >= len_eff;
    end

    assign thr = THR_W'(thr32);

    always_comb begin
        hdr_seg = '0;
        for (int s = 0; s < HDR_SEGS; s++) begin
            if (beat_cnt_q == BEAT_W'(s)) begin
                hdr_seg = s_hdr_data[s*W +: W];
            end
        end
    end

    seg_byte_merge #(
        .DATA_WIDTH (W),
        .THR_WIDTH  (THR_W)
    ) u_merge (
        .hdr_seg_i  (hdr_seg),
        .pkt_data_i (s_axis_tdata),
        .thr_i      (thr),
        .merged_o   (merged)
    );

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        byte_cnt_d = byte_cnt_q;
        case (state_q)
            IDLE: begin
                if (s_hdr_valid) begin
                    state_d = (len_eff == 32'd0) ? PASS : MERGE;
                end
            end
            MERGE: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    byte_cnt_d = byte_cnt_q + BYTE_W'(BPB);
                    if (hdr_done) begin
                        state_d = PASS;
                    end
                end
            end
            PASS: begin
                state_d = PASS;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Packet end wins from any state and re-arms for the next header.
        if (end_pkt) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            byte_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK_156) begin
        if (RESET_156) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    always_ff @(posedge CLK_156) begin
        if (RESET_156) begin
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tuser_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
        end else if (adv) begin
            m_tvalid_q <= accept;
            if (accept) begin
                m_tdata_q <= merged;
                m_tkeep_q <= s_axis_tkeep;
                m_tuser_q <= s_axis_tuser;
                m_tlast_q <= s_axis_tlast;
            end
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tuser  = m_tuser_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tvalid = m_tvalid_q;

`ifdef DEPARSER_STATS_EN
    logic [31:0] pkt_cnt_q, trunc_cnt_q, kept;
    logic        trunc_evt;

    // A packet is truncated when its kept bytes end before the header does.
    always_comb begin
        kept = '0;
        for (int b = 0; b < KW; b++) begin
            kept = kept + 32'(s_axis_tkeep[b]);
        end
        trunc_evt = (state_q == MERGE) && ((32'(byte_cnt_q) + kept) < len_eff);
    end

    always_ff @(posedge CLK_156) begin
        if (RESET_156) begin
            pkt_cnt_q   <= '0;
            trunc_cnt_q <= '0;
        end else if (end_pkt) begin
            if (pkt_cnt_q != '1) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
            if (trunc_evt && (trunc_cnt_q != '1)) begin
                trunc_cnt_q <= trunc_cnt_q + 32'd1;
            end
        end
    end

    assign stat_pkt_cnt   = pkt_cnt_q;
    assign stat_trunc_cnt = trunc_cnt_q;
`endif

endmodule

// File: tb/tb_phv_deparser_merge.sv
// Directed bench for phv_deparser_merge: header overlay, pass-through, truncation,
// backpressure, late header and mid-packet reset.
module tb_phv_deparser_merge;
    import deparser_pkg::*;

    localparam int W    = 256;
    localparam int KW   = 32;
    localparam int UW   = 128;
    localparam int SEGS = 4;
    localparam int LW   = 8;
    localparam int BB   = W + KW + 1 + UW;
    localparam int KO   = UW + 1;
    localparam int DO   = UW + 1 + KW;

    logic              CLK_156 = 1'b0;
    logic              RESET_156;
    logic [W-1:0]      s_axis_tdata;
    logic [KW-1:0]     s_axis_tkeep;
    logic [UW-1:0]     s_axis_tuser;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic [SEGS*W-1:0] s_hdr_data;
    logic [LW-1:0]     s_hdr_len;
    logic              s_hdr_valid;
    logic              s_hdr_ready;
    logic [W-1:0]      m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    state_t            dbg_state;
`ifdef DEPARSER_STATS_EN
    logic [31:0]       stat_pkt_cnt;
    logic [31:0]       stat_trunc_cnt;
`endif

    phv_deparser_merge dut (
        .CLK_156       (CLK_156),
        .RESET_156     (RESET_156),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_hdr_data    (s_hdr_data),
        .s_hdr_len     (s_hdr_len),
        .s_hdr_valid   (s_hdr_valid),
        .s_hdr_ready   (s_hdr_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .dbg_state     (dbg_state)
`ifdef DEPARSER_STATS_EN
        ,
        .stat_pkt_cnt  (stat_pkt_cnt),
        .stat_trunc_cnt(stat_trunc_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 CLK_156 = ~CLK_156;

    int cyc = 0;
    always @(posedge CLK_156) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [BB-1:0] exp_q[$];
    logic [BB-1:0] got_q[$];
    int r_pre_rdy, r_pulses, r_pulse_bad, r_held_bad, r_first_acc, r_first_out, r_drv_to;

    function automatic logic [7:0] hdr_byte(input int i);
        return 8'(i) ^ 8'h80;
    endfunction

    function automatic logic [7:0] pkt_byte(input int k, input int b);
        return 8'((k * 32 + b) % 128);
    endfunction

    function automatic logic [W-1:0] pkt_beat(input int k);
        logic [W-1:0] d;
        for (int b = 0; b < KW; b++) d[b*8 +: 8] = pkt_byte(k, b);
        return d;
    endfunction

    function automatic logic [UW-1:0] user_of(input int k);
        return UW'(32'hC0DE0000 + 32'(k));
    endfunction

    function automatic logic [KW-1:0] keep_of(input int k, input int n, input logic [KW-1:0] lk);
        return (k == n - 1) ? lk : '1;
    endfunction

    // Bytes outside tkeep carry no meaning and are zeroed before comparison.
    function automatic logic [BB-1:0] mask_beat(input logic [BB-1:0] x);
        logic [BB-1:0] r;
        r = x;
        for (int b = 0; b < KW; b++) if (!x[KO + b]) r[DO + b*8 +: 8] = 8'h00;
        return r;
    endfunction

    function automatic logic [BB-1:0] exp_beat(input int k, input int n, input logic [KW-1:0] lk,
                                               input int len_eff);
        logic [W-1:0] d;
        for (int b = 0; b < KW; b++) begin
            d[b*8 +: 8] = ((k * 32 + b) < len_eff) ? hdr_byte(k * 32 + b) : pkt_byte(k, b);
        end
        return mask_beat({d, keep_of(k, n, lk), (k == n - 1), user_of(k)});
    endfunction

    // ---------------- driver ----------------
    task automatic drive_beat(input int k, input int n, input logic [KW-1:0] lk);
        s_axis_tdata  = pkt_beat(k);
        s_axis_tkeep  = keep_of(k, n, lk);
        s_axis_tuser  = user_of(k);
        s_axis_tlast  = (k == n - 1);
        s_axis_tvalid = 1'b1;
    endtask

    task automatic run_pkt(input int n, input logic [KW-1:0] lk, input int len, input int mode,
                           input int delay);
        got_q.delete();
        r_pre_rdy = 0; r_pulses = 0; r_pulse_bad = 0; r_held_bad = 0;
        r_first_acc = -1; r_first_out = -1; r_drv_to = 0;
        s_hdr_len = LW'(len);
        fork
            begin : drv
                if (delay > 0) begin
                    drive_beat(0, n, lk);
                    s_hdr_valid = 1'b0;
                    repeat (delay) begin
                        @(negedge CLK_156);
                        if (s_axis_tready) r_pre_rdy++;
                        @(posedge CLK_156); #1;
                    end
                end
                s_hdr_valid = 1'b1;
                for (int k = 0; k < n; k++) begin
                    int w;
                    drive_beat(k, n, lk);
                    w = 0;
                    @(negedge CLK_156);
                    while (!s_axis_tready && w < 50) begin
                        @(negedge CLK_156);
                        w++;
                    end
                    if (!s_axis_tready) r_drv_to++;
                    @(posedge CLK_156); #1;
                end
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                s_hdr_valid   = 1'b0;
            end
            begin : col
                int w2;
                w2 = 0;
                while (got_q.size() < n && w2 < 300) begin
                    m_axis_tready = (mode == 0) ? 1'b1 : ((w2 % 2) == 0);
                    @(negedge CLK_156);
                    if (m_axis_tvalid && !m_axis_tready && s_axis_tready) r_held_bad++;
                    if (s_hdr_ready) begin
                        r_pulses++;
                        if (!(s_axis_tvalid && s_axis_tready && s_axis_tlast)) r_pulse_bad++;
                    end
                    if (r_first_acc < 0 && s_axis_tvalid && s_axis_tready) r_first_acc = cyc;
                    if (r_first_out < 0 && m_axis_tvalid) r_first_out = cyc;
                    if (m_axis_tvalid && m_axis_tready)
                        got_q.push_back(mask_beat({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}));
                    @(posedge CLK_156); #1;
                    w2++;
                end
                m_axis_tready = 1'b1;
            end
        join
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int bad;
        RESET_156 = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
        s_axis_tuser = '0; s_hdr_valid = 1'b0; s_hdr_len = '0; m_axis_tready = 1'b1;
        repeat (3) @(posedge CLK_156);
        @(negedge CLK_156);
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
            $display("FAIL reset_mvalid_mlast: got %b%b expected 00", m_axis_tvalid, m_axis_tlast); n_fail++;
        end
        n_checks++;
        if (m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axis_tuser !== '0) begin
            $display("FAIL reset_mdata: got %h/%h/%h expected zeros", m_axis_tdata, m_axis_tkeep, m_axis_tuser); n_fail++;
        end
        n_checks++;
        if (s_axis_tready !== 1'b0 || s_hdr_ready !== 1'b0) begin
            $display("FAIL reset_readies: got %b%b expected 00", s_axis_tready, s_hdr_ready); n_fail++;
        end
        n_checks++;
        if (dbg_state !== IDLE) begin
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); n_fail++;
        end
`ifdef DEPARSER_STATS_EN
        n_checks++;
        if (stat_pkt_cnt !== 32'd0 || stat_trunc_cnt !== 32'd0) begin
            $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_pkt_cnt, stat_trunc_cnt); n_fail++;
        end
`endif
        @(posedge CLK_156); #1;
        RESET_156 = 1'b0;
        drive_beat(0, 1, '1);
        bad = 0;
        repeat (4) begin
            @(negedge CLK_156);
            if (s_axis_tready !== 1'b0) bad++;
            @(posedge CLK_156); #1;
        end
        n_checks++;
        if (bad != 0) begin
            $display("FAIL no_hdr_no_accept: got %0d ready cycles expected 0", bad); n_fail++;
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        @(posedge CLK_156); #1;
    endtask

    task automatic test_hdr54();
        logic [BB-1:0] e, g;
        run_pkt(3, 32'h0000FFFF, 54, 0, 0);
        n_checks++;
        if (got_q.size() != 3) begin
            $display("FAIL hdr54_count: got %0d expected 3", got_q.size()); n_fail++;
        end
        for (int k = 0; k < 3; k++) begin
            e = exp_beat(k, 3, 32'h0000FFFF, 54);
            g = (k < got_q.size()) ? got_q[k] : '0;
            n_checks++;
            if (g !== e) begin
                $display("FAIL hdr54_beat%0d: got %h expected %h", k, g, e); n_fail++;
            end
        end
        g = (got_q.size() > 1) ? got_q[1] : '0;
        n_checks++;
        if (g[DO + 21*8 +: 8] !== 8'hB5 || g[DO + 22*8 +: 8] !== 8'h36) begin
            $display("FAIL hdr54_boundary: got %h %h expected b5 36", g[DO + 21*8 +: 8], g[DO + 22*8 +: 8]); n_fail++;
        end
        n_checks++;
        if (r_pulses != 1 || r_pulse_bad != 0 || r_drv_to != 0) begin
            $display("FAIL hdr54_hdr_ready: got pulses %0d bad %0d timeouts %0d expected 1 0 0", r_pulses, r_pulse_bad, r_drv_to); n_fail++;
        end
    endtask

    task automatic test_passthrough();
        logic [BB-1:0] e, g;
        run_pkt(2, '1, 0, 0, 0);
        n_checks++;
        if (got_q.size() != 2) begin
            $display("FAIL pass_count: got %0d expected 2", got_q.size()); n_fail++;
        end
        for (int k = 0; k < 2; k++) begin
            e = mask_beat({pkt_beat(k), 32'hFFFFFFFF, (k == 1), user_of(k)});
            g = (k < got_q.size()) ? got_q[k] : '0;
            n_checks++;
            if (g !== e) begin
                $display("FAIL pass_beat%0d: got %h expected %h", k, g, e); n_fail++;
            end
        end
        n_checks++;
        if (r_first_out - r_first_acc != 1) begin
            $display("FAIL pass_latency: got %0d expected 1", r_first_out - r_first_acc); n_fail++;
        end
    endtask

    task automatic test_truncate();
        logic [BB-1:0] e, g;
        run_pkt(1, 32'h000000FF, 128, 0, 0);
        e = exp_beat(0, 1, 32'h000000FF, 128);
        g = (got_q.size() > 0) ? got_q[0] : '0;
        n_checks++;
        if (got_q.size() != 1 || g !== e) begin
            $display("FAIL trunc_beat: got %0d beats %h expected 1 beat %h", got_q.size(), g, e); n_fail++;
        end
        n_checks++;
        if (g[KO +: KW] !== 32'h000000FF || g[DO + 7*8 +: 8] !== 8'h87) begin
            $display("FAIL trunc_keep_byte7: got %h %h expected 000000ff 87", g[KO +: KW], g[DO + 7*8 +: 8]); n_fail++;
        end
`ifdef DEPARSER_STATS_EN
        n_checks++;
        if (stat_pkt_cnt !== 32'd3 || stat_trunc_cnt !== 32'd1) begin
            $display("FAIL trunc_stats: got %0d/%0d expected 3/1", stat_pkt_cnt, stat_trunc_cnt); n_fail++;
        end
`endif
    endtask

    task automatic test_len_clamp();
        logic [BB-1:0] e, g;
        run_pkt(5, '1, 200, 0, 0);
        n_checks++;
        if (got_q.size() != 5) begin
            $display("FAIL clamp_count: got %0d expected 5", got_q.size()); n_fail++;
        end
        for (int k = 0; k < 5; k++) begin
            e = exp_beat(k, 5, '1, 128);
            g = (k < got_q.size()) ? got_q[k] : '0;
            n_checks++;
            if (g !== e) begin
                $display("FAIL clamp_beat%0d: got %h expected %h", k, g, e); n_fail++;
            end
        end
`ifdef DEPARSER_STATS_EN
        n_checks++;
        if (stat_pkt_cnt !== 32'd4 || stat_trunc_cnt !== 32'd1) begin
            $display("FAIL clamp_stats: got %0d/%0d expected 4/1", stat_pkt_cnt, stat_trunc_cnt); n_fail++;
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [BB-1:0] e, g;
        run_pkt(6, 32'h00FFFFFF, 70, 1, 0);
        n_checks++;
        if (got_q.size() != 6) begin
            $display("FAIL bp_count: got %0d expected 6", got_q.size()); n_fail++;
        end
        for (int k = 0; k < 6; k++) begin
            e = exp_beat(k, 6, 32'h00FFFFFF, 70);
            g = (k < got_q.size()) ? got_q[k] : '0;
            n_checks++;
            if (g !== e) begin
                $display("FAIL bp_beat%0d: got %h expected %h", k, g, e); n_fail++;
            end
        end
        n_checks++;
        if (r_held_bad != 0 || r_pulses != 1 || r_pulse_bad != 0) begin
            $display("FAIL bp_handshake: got held %0d pulses %0d bad %0d expected 0 1 0", r_held_bad, r_pulses, r_pulse_bad); n_fail++;
        end
    endtask

    task automatic test_late_hdr();
        logic [BB-1:0] e, g;
        run_pkt(2, '1, 40, 0, 5);
        n_checks++;
        if (r_pre_rdy != 0) begin
            $display("FAIL late_hdr_ready: got %0d ready cycles expected 0", r_pre_rdy); n_fail++;
        end
        for (int k = 0; k < 2; k++) begin
            e = exp_beat(k, 2, '1, 40);
            g = (k < got_q.size()) ? got_q[k] : '0;
            n_checks++;
            if (g !== e) begin
                $display("FAIL late_hdr_beat%0d: got %h expected %h", k, g, e); n_fail++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [BB-1:0] e, g;
        int w;
        s_hdr_len = LW'(54);
        s_hdr_valid = 1'b1;
        m_axis_tready = 1'b1;
        drive_beat(0, 4, '1);
        w = 0;
        @(negedge CLK_156);
        while (!s_axis_tready && w < 50) begin
            @(negedge CLK_156);
            w++;
        end
        @(posedge CLK_156); #1;
        drive_beat(1, 4, '1);
        RESET_156 = 1'b1;
        @(posedge CLK_156); #1;
        RESET_156 = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_hdr_valid = 1'b0;
        @(negedge CLK_156);
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || s_hdr_ready !== 1'b0 || dbg_state !== IDLE) begin
            $display("FAIL midreset_outputs: got valid %b hdr_ready %b state %0d expected 0 0 0", m_axis_tvalid, s_hdr_ready, dbg_state); n_fail++;
        end
        @(posedge CLK_156); #1;
        run_pkt(4, '1, 54, 0, 0);
        n_checks++;
        if (got_q.size() != 4) begin
            $display("FAIL midreset_count: got %0d expected 4", got_q.size()); n_fail++;
        end
        for (int k = 0; k < 4; k++) begin
            e = exp_beat(k, 4, '1, 54);
            g = (k < got_q.size()) ? got_q[k] : '0;
            n_checks++;
            if (g !== e) begin
                $display("FAIL midreset_beat%0d: got %h expected %h", k, g, e); n_fail++;
            end
        end
`ifdef DEPARSER_STATS_EN
        n_checks++;
        if (stat_pkt_cnt !== 32'd1 || stat_trunc_cnt !== 32'd0) begin
            $display("FAIL midreset_stats: got %0d/%0d expected 1/0", stat_pkt_cnt, stat_trunc_cnt); n_fail++;
        end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < SEGS * KW; i++) s_hdr_data[i*8 +: 8] = hdr_byte(i);
        test_reset();
        test_hdr54();
        test_passthrough();
        test_truncate();
        test_len_clamp();
        test_backpressure();
        test_late_hdr();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phv_deparser_merge.md
Name: phv_deparser_merge

Overview:
- Parametrised successor to the single-width header reassembler in the T-processing path.
- Merges a modified packet header vector (PHV header bytes plus header length) back into the original packet stream.
- Header bytes overwrite the leading packet bytes; the remainder of the packet passes through.
- Generalised in data width and header segment count, with full AXIS backpressure on every beat (including tail pass-through), a registered output stage, and defined truncation behaviour.

Parameters:
C_S_AXIS_DATA_WIDTH, 256, packet/output tdata width in bits, multiple of 64
C_S_AXIS_TUSER_WIDTH, 128, tuser width, passed through unchanged
HDR_SEGS, 4, max header span in beats; header buffer = HDR_SEGS*C_S_AXIS_DATA_WIDTH bits
LEN_WIDTH, 8, width of header byte-length field; must hold HDR_SEGS*C_S_AXIS_DATA_WIDTH/8

Ports:
CLK_156  in  1  clock
RESET_156  in  1  synchronous active-high reset
s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  original packet data
s_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  byte enables, contiguous from bit 0
s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  metadata
s_axis_tvalid  in  1  packet beat valid
s_axis_tready  out  1  packet beat accept
s_axis_tlast  in  1  last beat
s_hdr_data  in  HDR_SEGS*C_S_AXIS_DATA_WIDTH  modified header, byte 0 at bit 0
s_hdr_len  in  LEN_WIDTH  valid header bytes
s_hdr_valid  in  1  header vector valid
s_hdr_ready  out  1  header consumed, pulses on packet tlast accept
m_axis_tdata/tkeep/tuser/tlast  out  as slave  merged stream, registered
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream accept

Behaviour:
- One clock (CLK_156). Reset is synchronous, active-high (RESET_156).
- Reset values:
  - all m_axis_* outputs 0; s_axis_tready 0; s_hdr_ready 0.
  - state IDLE; beat_cnt 0; byte_cnt 0.
- Output stage: single register. Define adv = !m_axis_tvalid | m_axis_tready.
  - Input-to-output latency is 1 cycle.
  - No combinational path from m_axis_tready to m_axis_tdata.
- IDLE:
  - s_axis_tready = 0.
  - When s_hdr_valid=1: go to MERGE (or PASS if effective length is 0).
  - Packet beats are never accepted without a header.
- MERGE:
  - s_axis_tready = adv.
  - On an accepted beat: byte b of the output = header byte (beat_cnt*W/8+b) if that index < hdr_len_eff, else packet byte b.
  - tkeep, tuser, tlast are always taken from the packet beat.
  - beat_cnt increments on each accept.
  - When byte_cnt+W/8 >= hdr_len_eff, go to PASS.
- PASS:
  - s_axis_tready = adv; data copied unmodified.
  - Backpressure is honoured on every beat.
- Any state, accept with s_axis_tlast=1:
  - s_hdr_ready = 1 for that cycle.
  - Go to IDLE; clear counters.
- hdr_len_eff = min(s_hdr_len, HDR_SEGS*W/8).
- Header longer than packet: excess header bytes are dropped. Output length always equals input packet length; tkeep is never widened.
- s_hdr_len = 0: pure pass-through.
- Header arriving while its packet is in flight is not sampled until IDLE; s_hdr_* must remain stable while valid.
- Reset mid-packet: both outputs go invalid next cycle. Upstream must restart on a packet boundary.

Optional Feature:
DEPARSER_STATS_EN
- Defined: adds output ports stat_pkt_cnt[31:0] and stat_trunc_cnt[31:0].
  - stat_pkt_cnt increments on each tlast accept.
  - stat_trunc_cnt increments when a packet ends while still in MERGE, i.e. the header exceeded the packet.
  - Both saturate at all-ones; both clear on reset.
- Not defined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package deparser_pkg:
  - state enum (IDLE, MERGE, PASS).
  - BYTES_PER_BEAT and header-byte-count localparams.
  - clog2-based counter widths.
- Sub-module seg_byte_merge (combinational): per-byte mux for header segment vs packet beat, driven by a byte-threshold input.
- The FSM, counters and output register live in the top module.

Test Plan:
- hdr_len=54, 3-beat packet (tkeep all-ones ×2, last 0x0000FFFF), m_axis_tready=1 -> beat0 all header; beat1 bytes 0-21 header, 22-31 packet; beat2 packet; s_hdr_ready single pulse on beat2.
- hdr_len=0, 2-beat packet -> output bit-identical to input; latency 1.
- hdr_len=128, 1-beat packet with tkeep=0x000000FF -> output tkeep 0x000000FF, header bytes 0-7 only; stat_trunc_cnt=1 when DEPARSER_STATS_EN.
- m_axis_tready toggling 1010… over a 6-beat packet, hdr_len=70 -> no beat lost or duplicated; s_axis_tready low whenever output is held.
- Packet valid before header (header 5 cycles late) -> s_axis_tready stays 0 until s_hdr_valid; then normal merge.
- RESET_156 asserted on beat 2 of 4 -> next cycle m_axis_tvalid=0, s_hdr_ready=0; next packet merges correctly.
